// File: rtl/fifo_pkg.sv
// Shared sizing and pointer helpers for the flip-flop FIFO family.
package fifo_pkg;

    // Pointer width for a given depth; never narrower than one bit.
    function automatic int ptr_w(input int d);
        return ($clog2(d) > 1) ? $clog2(d) : 1;
    endfunction

    // Occupancy counter width, able to hold 0..depth inclusive.
    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    // Modulo-depth increment: wraps depth-1 back to 0 for any depth.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned d);
        return (ptr >= d - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ff_fifo_any_depth_chk.sv
// Elaboration-time parameter legality checks for ff_fifo_any_depth.
module ff_fifo_any_depth_chk #(
    parameter int depth              = 5,
    parameter int almost_full_level  = 4,
    parameter int almost_empty_level = 1
);

    if (depth < 2) begin : g_bad_depth
        $error("ff_fifo_any_depth: depth must be at least 2");
    end

    if ((almost_full_level < 1) || (almost_full_level > depth)) begin : g_bad_afl
        $error("ff_fifo_any_depth: almost_full_level must be within 1..depth");
    end

    if ((almost_empty_level < 0) || (almost_empty_level >= depth)) begin : g_bad_ael
        $error("ff_fifo_any_depth: almost_empty_level must be within 0..depth-1");
    end

endmodule

// File: rtl/ff_fifo_wrap_ptr.sv
// Modulo-depth pointer register used for both FIFO read and write sides.
module ff_fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int depth = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      inc,
    output logic [ptr_w(depth)-1:0]   ptr
);

    localparam int PTR_W = ptr_w(depth);

    logic [PTR_W-1:0] ptr_r;

    // Pointer state: async reset, synchronous clear, wrap-around increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (clear) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            ptr_r <= PTR_W'(next_ptr(32'(ptr_r), 32'(depth)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/ff_fifo_any_depth.sv
// Show-ahead single-clock flip-flop FIFO for any depth >= 2, with occupancy
// count, almost flags, synchronous flush and sticky error flags.
module ff_fifo_any_depth
    import fifo_pkg::*;
#(
    parameter int width              = 8,
    parameter int depth              = 5,
    parameter int almost_full_level  = 4,
    parameter int almost_empty_level = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [width-1:0]          write_data,
    output logic [width-1:0]          read_data,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(depth)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PTR_W = ptr_w(depth);
    localparam int CNT_W = cnt_w(depth);

    logic [width-1:0] mem_r [depth];
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic             empty_s;
    logic             full_s;

    ff_fifo_any_depth_chk #(
        .depth              (depth),
        .almost_full_level  (almost_full_level),
        .almost_empty_level (almost_empty_level)
    ) u_chk ();

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_W'(depth));

    // A pop into an empty FIFO never falls through; a push into a full FIFO
    // is allowed only when the same cycle frees a slot.
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);

    ff_fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (push_ok_s),
        .ptr   (wr_ptr_s)
    );

    ff_fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (pop_ok_s),
        .ptr   (rd_ptr_s)
    );

    // Storage write; contents are deliberately not reset, and a flush drops the push.
    always_ff @(posedge clk) begin
        if (push_ok_s && !clear) begin
            mem_r[wr_ptr_s] <= write_data;
        end
    end

    // Occupancy tracking: simultaneous accepted push and pop cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags, held until reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r  | (push & full_s & ~pop_ok_s);
            underflow_r <= underflow_r | (pop & empty_s);
        end
    end

    assign read_data    = mem_r[rd_ptr_s];
    assign count        = count_r;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_full  = (count_r >= CNT_W'(almost_full_level));
    assign almost_empty = (count_r <= CNT_W'(almost_empty_level));
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_ff_fifo_any_depth.sv
// Self-checking bench for ff_fifo_any_depth: directed plan plus random traffic
// compared against a queue-based reference model.
module tb_ff_fifo_any_depth;

    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int AFL   = 4;
    localparam int AEL   = 1;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         push;
    logic         pop;
    logic [W-1:0] write_data;
    logic [W-1:0] read_data;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic         almost_empty;
    logic [2:0]   count;
    logic         overflow;
    logic         underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] q[$];
    bit           m_ovf;
    bit           m_unf;

    ff_fifo_any_depth #(
        .width              (W),
        .depth              (DEPTH),
        .almost_full_level  (AFL),
        .almost_empty_level (AEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .write_data   (write_data),
        .read_data    (read_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all();
        chk("count", {29'd0, count}, q.size());
        chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
        chk("almost_full", {31'd0, almost_full}, {31'd0, q.size() >= AFL});
        chk("almost_empty", {31'd0, almost_empty}, {31'd0, q.size() <= AEL});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
        if (q.size() > 0) chk("read_data", {24'd0, read_data}, {24'd0, q[0]});
    endtask

    // One clock cycle of stimulus, model update, then full comparison.
    task automatic step(input bit pu, input bit po, input logic [W-1:0] d, input bit cl);
        bit was_empty;
        bit was_full;
        bit pop_acc;
        bit push_acc;
        push = pu; pop = po; write_data = d; clear = cl;
        @(posedge clk);
        #1;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        if (cl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_acc  = po && !was_empty;
            push_acc = pu && (!was_full || pop_acc);
            if (po && was_empty) m_unf = 1'b1;
            if (pu && was_full && !pop_acc) m_ovf = 1'b1;
            if (pop_acc) void'(q.pop_front());
            if (push_acc) q.push_back(d);
        end
        push = 1'b0; pop = 1'b0; clear = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; write_data = 8'h00;
        m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // Fill: count 1..5, head stays 0x11
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i * 8'h11), 1'b0);
        chk("fill_head", {24'd0, read_data}, 32'h11);
        chk("fill_full", {31'd0, full}, 32'd1);

        // Drain 3, push 3 across the wrap, drain 5
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Simultaneous push/pop at full and at empty
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0);
        chk("pp_full_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("pp_empty_data", {24'd0, read_data}, 32'h77);
        chk("pp_empty_unf", {31'd0, underflow}, 32'd1);

        // Overflow stickiness, then clear
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'hC5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Clear with push at count=3: the push is dropped
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        step(1'b1, 1'b0, 8'h99, 1'b1);
        chk("clr_count", {29'd0, count}, 32'd0);
        step(1'b1, 1'b0, 8'h42, 1'b0);
        chk("clr_no99", {24'd0, read_data}, 32'h42);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Async reset between edges at count=2
        step(1'b1, 1'b0, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        #2 rst = 1'b1;
        #1;
        q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_count", {29'd0, count}, 32'd0);
        #2 rst = 1'b0;
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        chk("arst_push", {24'd0, read_data}, 32'h5A);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                 8'($urandom), ($urandom_range(0, 99) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ff_fifo_any_depth.md
Name: ff_fifo_any_depth

Overview:
- Show-ahead single-clock flip-flop FIFO for any depth ≥ 2, not only powers of two.
- Successor of the power-of-two FIFO. Adds an occupancy count, almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags.
- Used as a generic buffer between pipeline stages and in the single-cycle CPU testbenches.

Parameters:
- width, 8, data word width in bits (≥ 1).
- depth, 5, number of entries (≥ 2, any integer).
- almost_full_level, 4, almost_full asserts when count ≥ this value (1..depth).
- almost_empty_level, 1, almost_empty asserts when count ≤ this value (0..depth-1).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous flush of contents and error flags.
- push  input  1  write request.
- pop  input  1  read request.
- write_data  input  width  data to write.
- read_data  output  width  head entry, valid while empty is 0.
- empty  output  1  count == 0.
- full  output  1  count == depth.
- almost_full  output  1  count ≥ almost_full_level.
- almost_empty  output  1  count ≤ almost_empty_level.
- count  output  $clog2(depth+1)  current occupancy, 0..depth.
- overflow  output  1  sticky: a push was attempted while full with no accepted pop.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. Reset clears wr_ptr, rd_ptr, count, overflow and underflow to 0. Immediately after reset: empty=1, full=0, almost_empty=1, almost_full=0. Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are $clog2(depth) bits wide. Each wraps from depth-1 to 0 on increment, with no power-of-two aliasing. Full/empty are derived from the registered count, not from pointer comparison.
- Accepted operations:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - Push into a full FIFO is accepted only when a pop is accepted in the same cycle.
- Storage: on push_ok, mem[wr_ptr] <= write_data and wr_ptr advances. On pop_ok, rd_ptr advances.
- Count update: count + push_ok − pop_ok, so simultaneous push and pop leaves count unchanged.
- Read latency: read_data = mem[rd_ptr], combinational from registered state. A word pushed at edge N is visible on read_data after edge N.
- Empty with push and pop together: the push is accepted, the pop is rejected (no fall-through), and underflow sets. Count becomes 1.
- Error flags:
  - overflow sets on push & full & ~pop_ok.
  - underflow sets on pop & empty.
  - Both hold until rst or clear. Rejected operations leave data, pointers and count unchanged.
- clear: synchronous and has priority over push/pop in the same cycle. Pointers, count and both error flags go to 0; the push in that cycle is dropped.
- Flags are combinational decodes of the registered count and are glitch-free relative to clk.
- Reset mid-operation: state returns to the reset values immediately and asynchronously; the next edge after deassertion behaves as from empty.
- Elaboration checks (simulation only): depth ≥ 2, 1 ≤ almost_full_level ≤ depth, almost_empty_level < depth.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_w(depth) returning max(1, $clog2(depth));
  - function cnt_w(depth) returning $clog2(depth+1);
  - the mod-depth increment function next_ptr(ptr, depth).
- One sub-module: ff_fifo_wrap_ptr (parameter depth).
  - Ports: clk, rst, clear, inc, ptr.
  - Function: a modulo-depth pointer register; instantiated twice, for write and read.

Test Plan:
- Fill depth=5: push 0x11..0x55 on consecutive cycles. Count goes 1..5; almost_full rises with count=4; full=1 after the 5th; read_data stays 0x11 throughout; overflow stays 0.
- Drain and wrap: from full, pop 3, push 0xA0,0xA1,0xA2, then pop 5. Pops return 0x44,0x55,0xA0,0xA1,0xA2, confirming wr_ptr wrapped 4→0→1 correctly. Ends with empty=1, count=0.
- Simultaneous push and pop: at count=5, push 0x66 with pop. Count stays 5, full stays 1, overflow stays 0, head advances. At count=0, push 0x77 with pop: count=1, read_data=0x77, underflow=1.
- Error stickiness: push while full without pop sets overflow=1. Contents and count are unchanged. Overflow stays 1 through later normal traffic until clear=1, after which count=0 and both flags are 0.
- clear with push: clear=1 and push=1 (0x99) at count=3. Next cycle count=0, empty=1; 0x99 is never read.
- Async reset: assert rst between edges at count=2. empty=1 and count=0 take effect before the next edge; after release, a push of 0x5A reads back 0x5A.
